cdb_arbiter: RTL and testbench

- Arbitrates functional-unit (FU) writeback requests onto the NUM_CDB common data bus lanes that feed the physical register file write ports and the reservation-station wakeup logic.
- Up to NUM_FU result producers compete each cycle; round-robin priority guarantees starvation freedom.
- Output lanes are registered, so the CDB sees a clean, compacted set of (valid, tag, data) per cycle.

---
 rtl/cdb_arbiter.sv | 130 +++++++++++++
 tb/tb_cdb_arbiter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Round-robin writeback arbiter: compacts up to NUM_CDB FU results per cycle onto registered CDB lanes.
// Optional statistics counters are enabled with `define CDB_ARB_STATS_EN.
module cdb_arbiter #(
   parameter int NUM_FU  = 6,
   parameter int NUM_CDB = 4,
   parameter int TAG_W   = 8,
   parameter int DATA_W  = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       flush,
   input  logic [NUM_FU-1:0]          fu_valid,
   input  logic [NUM_FU*TAG_W-1:0]    fu_tag,
   input  logic [NUM_FU*DATA_W-1:0]   fu_data,
   output logic [NUM_FU-1:0]          fu_ready,
   output logic [NUM_CDB-1:0]         cdb_valid,
   output logic [NUM_CDB*TAG_W-1:0]   cdb_tag,
   output logic [NUM_CDB*DATA_W-1:0]  cdb_data
`ifdef CDB_ARB_STATS_EN
   ,
   output logic [31:0]                stat_grants,
   output logic [31:0]                stat_conflicts
`endif
);

   localparam int PTR_W = $clog2(NUM_FU);
   localparam int CNT_W = $clog2(NUM_CDB + 1);

   logic [PTR_W-1:0]          r_rr_ptr;
   logic [NUM_CDB-1:0]        r_cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]  r_cdb_tag;
   logic [NUM_CDB*DATA_W-1:0] r_cdb_data;

   logic [NUM_FU-1:0]         w_ready;
   logic [NUM_CDB-1:0]        w_lane_vld;
   logic [PTR_W-1:0]          w_lane_fu [NUM_CDB];
   logic [PTR_W-1:0]          w_next_ptr;
   logic                      w_any_grant;
   logic                      w_denied;
   logic [CNT_W-1:0]          w_num_grant;

   // Scan from rr_ptr; tag-0 results are consumed without taking a lane.
   always_comb begin
      int idx;
      int cnt;
      w_ready     = '0;
      w_lane_vld  = '0;
      w_next_ptr  = r_rr_ptr;
      w_any_grant = 1'b0;
      w_denied    = 1'b0;
      cnt         = 0;
      idx         = 0;
      for (int l = 0; l < NUM_CDB; l++) begin
         w_lane_fu[l] = '0;
      end
      for (int k = 0; k < NUM_FU; k++) begin
         idx = (int'(r_rr_ptr) + k) % NUM_FU;
         if (fu_valid[idx] && !reset && !flush) begin
            if (fu_tag[idx*TAG_W +: TAG_W] == '0) begin
               w_ready[idx] = 1'b1;
            end else if (cnt < NUM_CDB) begin
               w_ready[idx] = 1'b1;
               for (int l = 0; l < NUM_CDB; l++) begin
                  if (l == cnt) begin
                     w_lane_vld[l] = 1'b1;
                     w_lane_fu[l]  = PTR_W'(idx);
                  end
               end
               cnt         = cnt + 1;
               w_next_ptr  = (idx == NUM_FU - 1) ? '0 : PTR_W'(idx + 1);
               w_any_grant = 1'b1;
            end else begin
               w_denied = 1'b1;
            end
         end
      end
      w_num_grant = CNT_W'(cnt);
   end

   assign fu_ready = w_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_cdb_valid <= '0;
         r_cdb_tag   <= '0;
         r_cdb_data  <= '0;
         r_rr_ptr    <= '0;
      end else begin
         r_cdb_valid <= w_lane_vld;
         for (int l = 0; l < NUM_CDB; l++) begin
            if (w_lane_vld[l]) begin
               r_cdb_tag[l*TAG_W +: TAG_W]   <= fu_tag[w_lane_fu[l]*TAG_W +: TAG_W];
               r_cdb_data[l*DATA_W +: DATA_W] <= fu_data[w_lane_fu[l]*DATA_W +: DATA_W];
            end
         end
         if (w_any_grant) begin
            r_rr_ptr <= w_next_ptr;
         end
      end
   end

   assign cdb_valid = r_cdb_valid;
   assign cdb_tag   = r_cdb_tag;
   assign cdb_data  = r_cdb_data;

`ifdef CDB_ARB_STATS_EN
   logic [31:0] r_stat_grants;
   logic [31:0] r_stat_conflicts;
   logic [32:0] w_grant_sum;

   // Flush produces no grants and no denials, so both counters hold naturally.
   assign w_grant_sum = {1'b0, r_stat_grants} + 33'(w_num_grant);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stat_grants    <= '0;
         r_stat_conflicts <= '0;
      end else begin
         r_stat_grants <= w_grant_sum[32] ? '1 : w_grant_sum[31:0];
         if (w_denied && (r_stat_conflicts != '1)) begin
            r_stat_conflicts <= r_stat_conflicts + 32'd1;
         end
      end
   end

   assign stat_grants    = r_stat_grants;
   assign stat_conflicts = r_stat_conflicts;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed vector table followed by randomized traffic against a queue-based model.
module tb_cdb_arbiter;

   localparam int NUM_FU  = 6;
   localparam int NUM_CDB = 4;
   localparam int TAG_W   = 8;
   localparam int DATA_W  = 32;

   logic                       clk = 1'b0;
   logic                       reset;
   logic                       flush;
   logic [NUM_FU-1:0]          fu_valid;
   logic [NUM_FU*TAG_W-1:0]    fu_tag;
   logic [NUM_FU*DATA_W-1:0]   fu_data;
   logic [NUM_FU-1:0]          fu_ready;
   logic [NUM_CDB-1:0]         cdb_valid;
   logic [NUM_CDB*TAG_W-1:0]   cdb_tag;
   logic [NUM_CDB*DATA_W-1:0]  cdb_data;
`ifdef CDB_ARB_STATS_EN
   logic [31:0]                stat_grants;
   logic [31:0]                stat_conflicts;
`endif

   always #5 clk = ~clk;

   cdb_arbiter #(
      .NUM_FU(NUM_FU), .NUM_CDB(NUM_CDB), .TAG_W(TAG_W), .DATA_W(DATA_W)
   ) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
      .fu_ready(fu_ready),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data)
`ifdef CDB_ARB_STATS_EN
      , .stat_grants(stat_grants), .stat_conflicts(stat_conflicts)
`endif
   );

   int vectors     = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] data_of(input logic [7:0] t);
      return 32'hDEADBEDA + {24'h0, t};
   endfunction

   typedef struct {
      logic        rst;
      logic        fl;
      logic [5:0]  vld;
      logic [47:0] tags;
      logic [5:0]  ready;
      logic [3:0]  cv;
      logic [31:0] ct;
   } vec_t;

   vec_t tbl[20];

   // Behavioural model state
   int          m_rr;
   logic [3:0]  m_cv;
   logic [7:0]  m_ct [NUM_CDB];
   logic [31:0] m_cd [NUM_CDB];
   longint      m_sg;
   longint      m_sc;
   logic [5:0]  e_ready;
   int          e_gnt[$];
   bit          e_denied;

   logic        p_vld  [NUM_FU];
   logic [7:0]  p_tag  [NUM_FU];
   logic [31:0] p_data [NUM_FU];

   // Scan order is a rotated list; nonzero-tag requesters queue up and the first NUM_CDB win.
   task automatic model_eval(input logic rst, input logic fl);
      int order[$];
      int live[$];
      e_ready  = '0;
      e_gnt    = {};
      e_denied = 0;
      for (int k = 0; k < NUM_FU; k++) order.push_back((m_rr + k) % NUM_FU);
      foreach (order[j]) begin
         if (p_vld[order[j]] && !rst && !fl) begin
            if (p_tag[order[j]] == 8'h0) e_ready[order[j]] = 1'b1;
            else live.push_back(order[j]);
         end
      end
      foreach (live[j]) begin
         if (j < NUM_CDB) begin
            e_gnt.push_back(live[j]);
            e_ready[live[j]] = 1'b1;
         end
      end
      e_denied = (live.size() > NUM_CDB);
   endtask

   task automatic model_edge(input logic rst);
      if (rst) begin
         m_cv = '0;
         m_rr = 0;
         m_sg = 0;
         m_sc = 0;
         for (int l = 0; l < NUM_CDB; l++) begin
            m_ct[l] = '0;
            m_cd[l] = '0;
         end
      end else begin
         m_cv = '0;
         foreach (e_gnt[l]) begin
            m_cv[l] = 1'b1;
            m_ct[l] = p_tag[e_gnt[l]];
            m_cd[l] = p_data[e_gnt[l]];
         end
         if (e_gnt.size() > 0) m_rr = (e_gnt[e_gnt.size()-1] + 1) % NUM_FU;
         m_sg = m_sg + e_gnt.size();
         if (m_sg > 64'hFFFF_FFFF) m_sg = 64'hFFFF_FFFF;
         if (e_denied && m_sc < 64'hFFFF_FFFF) m_sc = m_sc + 1;
      end
   endtask

   task automatic run_table_row(input int i);
      vec_t v;
      v        = tbl[i];
      reset    = v.rst;
      flush    = v.fl;
      fu_valid = v.vld;
      fu_tag   = v.tags;
      for (int f = 0; f < NUM_FU; f++) fu_data[f*DATA_W +: DATA_W] = data_of(v.tags[f*TAG_W +: TAG_W]);
      #4;
      check($sformatf("tbl%0d fu_ready", i), 64'(fu_ready), 64'(v.ready));
      @(posedge clk);
      #1;
      check($sformatf("tbl%0d cdb_valid", i), 64'(cdb_valid), 64'(v.cv));
      check($sformatf("tbl%0d cdb_tag", i), 64'(cdb_tag), 64'(v.ct));
      if (v.rst) check($sformatf("tbl%0d cdb_data_reset", i), 64'(cdb_data), 64'h0);
      for (int l = 0; l < NUM_CDB; l++) begin
         if (v.cv[l]) check($sformatf("tbl%0d lane%0d data", i, l),
                            64'(cdb_data[l*DATA_W +: DATA_W]), 64'(data_of(v.ct[l*TAG_W +: TAG_W])));
      end
   endtask

   task automatic rnd_cycle(input logic force_rst);
      logic        rst;
      logic        fl;
      logic [31:0] exp_ct_w;
      logic [127:0] exp_cd_w;
      bit          uniq;
      logic [7:0]  t;
      for (int i = 0; i < NUM_FU; i++) begin
         if (!p_vld[i] && $urandom_range(9) < 6) begin
            p_vld[i]  = 1'b1;
            p_data[i] = $urandom;
            if ($urandom_range(9) == 0) p_tag[i] = 8'h0;
            else begin
               do begin
                  t    = 8'($urandom_range(255, 1));
                  uniq = 1;
                  for (int j = 0; j < NUM_FU; j++)
                     if (j != i && p_vld[j] && p_tag[j] == t) uniq = 0;
               end while (!uniq);
               p_tag[i] = t;
            end
         end
      end
      for (int i = 0; i < NUM_FU; i++)
         for (int j = i + 1; j < NUM_FU; j++)
            assert (!(p_vld[i] && p_vld[j] && p_tag[i] != 0 && p_tag[i] == p_tag[j]))
               else $error("duplicate nonzero tag in stimulus");
      rst   = force_rst || ($urandom_range(63) == 0);
      fl    = ($urandom_range(15) == 0);
      reset = rst;
      flush = fl;
      for (int i = 0; i < NUM_FU; i++) begin
         fu_valid[i]                  = p_vld[i];
         fu_tag[i*TAG_W +: TAG_W]     = p_tag[i];
         fu_data[i*DATA_W +: DATA_W]  = p_data[i];
      end
      model_eval(rst, fl);
      #4;
      check("rnd fu_ready", 64'(fu_ready), 64'(e_ready));
      @(posedge clk);
      model_edge(rst);
      #1;
      for (int l = 0; l < NUM_CDB; l++) begin
         exp_ct_w[l*TAG_W +: TAG_W]   = m_ct[l];
         exp_cd_w[l*DATA_W +: DATA_W] = m_cd[l];
      end
      check("rnd cdb_valid", 64'(cdb_valid), 64'(m_cv));
      check("rnd cdb_tag", 64'(cdb_tag), 64'(exp_ct_w));
      check("rnd cdb_data_lo", cdb_data[63:0], exp_cd_w[63:0]);
      check("rnd cdb_data_hi", cdb_data[127:64], exp_cd_w[127:64]);
`ifdef CDB_ARB_STATS_EN
      check("rnd stat_grants", 64'(stat_grants), 64'(m_sg));
      check("rnd stat_conflicts", 64'(stat_conflicts), 64'(m_sc));
`endif
      for (int i = 0; i < NUM_FU; i++) if (e_ready[i]) p_vld[i] = 1'b0;
   endtask

   localparam logic [47:0] ALL = 48'h06_05_04_03_02_01;

   initial begin
      reset    = 1'b1;
      flush    = 1'b0;
      fu_valid = '0;
      fu_tag   = '0;
      fu_data  = '0;

      tbl[0]  = '{1'b1, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[1]  = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[2]  = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[3]  = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[4]  = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[5]  = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[6]  = '{1'b0, 1'b0, 6'b000100, 48'h00_00_00_15_00_00, 6'b000100, 4'b0001, 32'h0000_0015};
      tbl[7]  = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0000_0015};
      tbl[8]  = '{1'b1, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};
      tbl[9]  = '{1'b0, 1'b0, 6'h3F, ALL, 6'b001111, 4'hF, 32'h0403_0201};
      tbl[10] = '{1'b0, 1'b0, 6'b110000, ALL, 6'b110000, 4'b0011, 32'h0403_0605};
      tbl[11] = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0403_0605};
      tbl[12] = '{1'b0, 1'b0, 6'b001010, 48'h00_00_20_00_00_00, 6'b001010, 4'b0001, 32'h0403_0620};
      tbl[13] = '{1'b0, 1'b0, 6'h3F, ALL, 6'b110011, 4'hF, 32'h0201_0605};
      tbl[14] = '{1'b0, 1'b1, 6'h3F, ALL, 6'h00, 4'h0, 32'h0201_0605};
      tbl[15] = '{1'b0, 1'b0, 6'h3F, ALL, 6'b111100, 4'hF, 32'h0605_0403};
      tbl[16] = '{1'b1, 1'b0, 6'h3F, ALL, 6'h00, 4'h0, 32'h0};
      tbl[17] = '{1'b0, 1'b0, 6'h3F, ALL, 6'b001111, 4'hF, 32'h0403_0201};
      tbl[18] = '{1'b1, 1'b1, 6'h3F, ALL, 6'h00, 4'h0, 32'h0};
      tbl[19] = '{1'b0, 1'b0, 6'h00, 48'h0, 6'h00, 4'h0, 32'h0};

      for (int i = 0; i < 20; i++) run_table_row(i);

      // Oversubscription counters: 6 grants over two cycles, one cycle with denials.
`ifdef CDB_ARB_STATS_EN
      reset = 1'b1; fu_valid = '0; #4; @(posedge clk); #1;
      reset = 1'b0; fu_valid = 6'h3F; fu_tag = ALL; #4; @(posedge clk); #1;
      fu_valid = 6'b110000; #4; @(posedge clk); #1;
      fu_valid = '0;
      check("stats grants", 64'(stat_grants), 64'd6);
      check("stats conflicts", 64'(stat_conflicts), 64'd1);
`endif

      for (int i = 0; i < NUM_FU; i++) begin
         p_vld[i]  = 1'b0;
         p_tag[i]  = '0;
         p_data[i] = '0;
      end
      m_rr = 0;
      rnd_cycle(1'b1);
      for (int c = 0; c < 1500; c++) rnd_cycle(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
